tia_pix_fifo: RTL and testbench
===============================

// Module: tia_pix_fifo
// PURPOSE
//  Pixel buffer between the beam-racing TIA pixel generator and the ILI9341 8-bit LCD writer.
//  Accepts 16-bit RGB565 pixels and cursor-reset markers at TIA pace, and replays them as
//  single-cycle pix_clk / reset_cursor strobes only when the LCD writer is idle.
//  Absorbs LCD busy jitter so the TIA beam never waits on the LCD per pixel, and counts dropped pixels.
// PARAMETERS
//  DEPTH          16  entries; power of 2, >= 4
//  AFULL_LEVEL    12  level at/above which afull_o asserts
//  HOLDOFF        2   cycles after a strobe during which lcd_busy_i is ignored (writer busy-rise latency)
// PORTS
//  clk_i          in   1   system clock (same 16 MHz domain as TIA and LCD writer)
//  resetn         in   1   asynchronous active-low reset
//  in_valid_i     in   1   pixel write strobe from TIA (one pixel per high cycle)
//  in_data_i      in   16  RGB565 pixel
//  in_sync_i      in   1   cursor reset request (start of frame)
//  afull_o        out  1   level >= AFULL_LEVEL; TIA uses it to hold its pixel counter
//  full_o         out  1   level == DEPTH
//  level_o        out  $clog2(DEPTH)+1  current entry count
//  ovf_cnt_o      out  8   saturating count of pixels dropped while full
//  pix_data_o     out  16  pixel to LCD writer, valid while pix_clk_o high
//  pix_clk_o      out  1   one-cycle pixel strobe to LCD writer
//  reset_cursor_o out  1   one-cycle cursor reset strobe to LCD writer
//  lcd_busy_i     in   1   LCD writer busy
// BEHAVIOUR
//  Reset: level 0, rd/wr ptr 0, ovf_cnt_o 0, pix_data_o 0, pix_clk_o 0, reset_cursor_o 0,
//   FSM IDLE, holdoff counter 0. All outputs are registered.
//  Storage: DEPTH x 17 bits {is_sync, data}; pointers wrap mod DEPTH; level derived from ptrs + wrap bit.
//  Write side, per cycle, priority order:
//   1. in_sync_i=1: flush (rd=wr, level 0), then write one entry {1,16'h0}; level becomes 1 next cycle.
//      Simultaneous in_valid_i is dropped, not counted. FSM mid-strobe (HOLD/WAIT) is not
//      aborted; the pending read in the same cycle is cancelled by the flush.
//   2. in_valid_i=1 and not full: write {0,in_data_i}.
//   3. in_valid_i=1 and full: drop pixel; ovf_cnt_o += 1, saturating at 8'hFF.
//   Simultaneous write and read while full: read frees a slot, but the write is judged against
//    the pre-read level, so it is dropped (no write-through).
//  Read FSM:
//   IDLE: if level>0 and !lcd_busy_i: pop head; if is_sync, pulse reset_cursor_o, else drive
//         pix_data_o=data and pulse pix_clk_o, for exactly 1 cycle (cycle after the pop decision);
//         load holdoff=HOLDOFF; go HOLD.
//   HOLD: decrement holdoff; at 0 go WAIT. lcd_busy_i ignored here.
//   WAIT: when lcd_busy_i==0 go IDLE (earliest next pop is the following cycle).
//  pix_data_o holds its last value between strobes; a sync entry does not change it.
//  Latency: write at cycle N into empty FIFO with IDLE and busy low -> strobe asserted in cycle N+2.
//  Throughput: at most one strobe per HOLDOFF+2 cycles; FIFO order strictly preserved.
//  afull_o/full_o/level_o reflect the registered level (post-update, visible the cycle after the write).
//  resetn assertion mid-operation: immediate clear of all state, including any strobe in flight.
// TESTING
//  T1 single pixel: write 16'hF800 into empty FIFO, busy=0 -> pix_clk_o=1 exactly once, 2 cycles later, data F800.
//  T2 ordering/backpressure: hold busy=1, write 10 pixels 0..9, release busy -> 10 strobes,
//     data 0..9 in order, >= HOLDOFF+2 cycles apart.
//  T3 overflow: busy=1, write DEPTH+3 pixels -> full_o=1, afull_o=1 from entry 12, ovf_cnt_o=3,
//     first DEPTH pixels delivered intact.
//  T4 sync flush: 5 pixels queued, busy=1, assert in_sync_i with in_valid_i -> level_o=1;
//     release busy -> one reset_cursor_o pulse, no pix_clk_o.
//  T5 saturation/reset: 300 drops -> ovf_cnt_o=FF; assert resetn=0 mid-strobe -> all outputs 0
//     asynchronously, level_o=0.

Source files
------------

// File: rtl/tia_pix_fifo_if.sv
// Pixel-path bundle between the TIA generator, the pixel FIFO and the LCD writer.
// Signal suffixes are from the FIFO's point of view.
interface tia_pix_fifo_if #(
    parameter int unsigned Depth = 16
) ();
    localparam int unsigned LvlW = $clog2(Depth) + 1;

    logic            in_valid_i;
    logic [15:0]     in_data_i;
    logic            in_sync_i;
    logic            lcd_busy_i;
    logic            afull_o;
    logic            full_o;
    logic [LvlW-1:0] level_o;
    logic [7:0]      ovf_cnt_o;
    logic [15:0]     pix_data_o;
    logic            pix_clk_o;
    logic            reset_cursor_o;

    modport master (
        output in_valid_i, in_data_i, in_sync_i, lcd_busy_i,
        input  afull_o, full_o, level_o, ovf_cnt_o, pix_data_o, pix_clk_o, reset_cursor_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_sync_i, lcd_busy_i,
        output afull_o, full_o, level_o, ovf_cnt_o, pix_data_o, pix_clk_o, reset_cursor_o
    );
endinterface

// File: rtl/tia_pix_fifo.sv
// Pixel/cursor-sync buffer between the TIA beam generator and the ILI9341 writer; replays
// entries as one-cycle strobes when the writer is idle and counts pixels dropped while full.
module tia_pix_fifo #(
    parameter int unsigned Depth      = 16,
    parameter int unsigned AfullLevel = 12,
    parameter int unsigned Holdoff    = 2
) (
    input logic            clk_i,
    input logic            resetn,
    tia_pix_fifo_if.slave  bus
);
    localparam int unsigned AW    = $clog2(Depth);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned HoldW = (Holdoff < 2) ? 1 : $clog2(Holdoff + 1);

    typedef enum logic [1:0] {StIdle, StHold, StWait} state_e;

    logic [16:0]      mem_q [Depth];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, afull_q;
    logic [7:0]       ovf_q, ovf_d;
    logic             mem_we;
    logic [16:0]      mem_wdata;

    state_e           state_q;
    logic [HoldW-1:0] hold_q;
    logic [15:0]      pix_data_q;
    logic             pix_clk_q;
    logic             rc_q;

    logic             pop;
    logic [16:0]      head;

    assign head = mem_q[rd_ptr_q[AW-1:0]];
    // A sync flush in the same cycle cancels the pending pop.
    assign pop  = (state_q == StIdle) && (level_q != '0) && !bus.lcd_busy_i && !bus.in_sync_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_wdata = {1'b0, bus.in_data_i};
        if (bus.in_sync_i) begin
            rd_ptr_d  = wr_ptr_q;
            mem_we    = 1'b1;
            mem_wdata = {1'b1, 16'h0000};
            wr_ptr_d  = wr_ptr_q + LW'(1);
        end else begin
            // Write judged against the pre-read level: no write-through when full.
            if (bus.in_valid_i && !full_q) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + LW'(1);
            end else if (bus.in_valid_i && full_q && (ovf_q != 8'hFF)) begin
                ovf_d = ovf_q + 8'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + LW'(1);
            end
        end
        level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LW'(Depth));
            afull_q  <= (level_d >= LW'(AfullLevel));
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            pix_data_q <= 16'h0000;
            pix_clk_q  <= 1'b0;
            rc_q       <= 1'b0;
        end else begin
            pix_clk_q <= 1'b0;
            rc_q      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        pix_clk_q <= !head[16];
                        rc_q      <= head[16];
                        if (!head[16]) begin
                            pix_data_q <= head[15:0];
                        end
                        hold_q  <= HoldW'(Holdoff);
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    // Writer busy is not trusted until its rise latency has elapsed.
                    if ((hold_q == '0) || (hold_q == HoldW'(1))) begin
                        state_q <= StWait;
                    end
                    if (hold_q != '0) begin
                        hold_q <= hold_q - HoldW'(1);
                    end
                end
                StWait: begin
                    if (!bus.lcd_busy_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.level_o        = level_q;
    assign bus.full_o         = full_q;
    assign bus.afull_o        = afull_q;
    assign bus.ovf_cnt_o      = ovf_q;
    assign bus.pix_data_o     = pix_data_q;
    assign bus.pix_clk_o      = pix_clk_q;
    assign bus.reset_cursor_o = rc_q;
endmodule

// File: tb/tb_tia_pix_fifo.sv
// Directed bench for tia_pix_fifo: per-cycle vector table plus hand sequences for
// overflow, sync flush, counter saturation and asynchronous reset.
module tb_tia_pix_fifo;
    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;

    tia_pix_fifo_if #(.Depth(16)) bus ();

    tia_pix_fifo #(
        .Depth      (16),
        .AfullLevel (12),
        .Holdoff    (2)
    ) dut (
        .clk_i  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sync;
        logic        valid;
        logic [15:0] data;
        logic        busy;
        logic        pclk;
        logic        rc;
        logic [15:0] pdata;
        logic [4:0]  lvl;
    } vec_t;

    vec_t vt [27];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid_i = 1'b0;
        bus.in_sync_i  = 1'b0;
        bus.in_data_i  = 16'h0000;
        bus.lcd_busy_i = 1'b0;
        resetn = 1'b0;
        #3;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int got;
        int last;
        int n_rc;
        int n_pc;
        bit seen;

        n_vec = 0;
        n_err = 0;

        vt[0]  = '{1'b0, 1'b1, 16'hF800, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1};
        vt[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hF800, 5'd0};
        vt[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hF800, 5'd0};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hF800, 5'd0};
        vt[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hF800, 5'd0};
        vt[5]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'hF800, 5'd1};
        vt[6]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 16'hF800, 5'd2};
        vt[7]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 16'hF800, 5'd3};
        vt[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0001, 5'd2};
        vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001, 5'd2};
        vt[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 5'd2};
        vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 5'd2};
        vt[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001, 5'd2};
        vt[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0002, 5'd1};
        vt[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002, 5'd1};
        vt[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002, 5'd1};
        vt[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002, 5'd1};
        vt[17] = '{1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0003, 5'd1};
        vt[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 5'd1};
        vt[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 5'd1};
        vt[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 5'd1};
        vt[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0004, 5'd0};
        vt[22] = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0004, 5'd1};
        vt[23] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0004, 5'd1};
        vt[24] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0004, 5'd1};
        vt[25] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0004, 5'd0};
        vt[26] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0004, 5'd0};

        // Reset state, checked while reset is held.
        bus.in_valid_i = 1'b0;
        bus.in_sync_i  = 1'b0;
        bus.in_data_i  = 16'h0000;
        bus.lcd_busy_i = 1'b0;
        resetn = 1'b0;
        #13;
        chk("rst_level", 0, 32'(bus.level_o), 32'd0);
        chk("rst_full", 0, 32'(bus.full_o), 32'd0);
        chk("rst_afull", 0, 32'(bus.afull_o), 32'd0);
        chk("rst_ovf", 0, 32'(bus.ovf_cnt_o), 32'd0);
        chk("rst_pdata", 0, 32'(bus.pix_data_o), 32'd0);
        chk("rst_pclk", 0, 32'(bus.pix_clk_o), 32'd0);
        chk("rst_rc", 0, 32'(bus.reset_cursor_o), 32'd0);
        step();
        resetn = 1'b1;

        // Table: row inputs held for one cycle, outputs checked just after that edge.
        for (int i = 0; i < 27; i++) begin
            bus.in_sync_i  = vt[i].sync;
            bus.in_valid_i = vt[i].valid;
            bus.in_data_i  = vt[i].data;
            bus.lcd_busy_i = vt[i].busy;
            step();
            chk("tbl_pclk", i, 32'(bus.pix_clk_o), 32'(vt[i].pclk));
            chk("tbl_rc", i, 32'(bus.reset_cursor_o), 32'(vt[i].rc));
            chk("tbl_pdata", i, 32'(bus.pix_data_o), 32'(vt[i].pdata));
            chk("tbl_level", i, 32'(bus.level_o), 32'(vt[i].lvl));
            chk("tbl_full", i, 32'(bus.full_o), 32'd0);
            chk("tbl_ovf", i, 32'(bus.ovf_cnt_o), 32'd0);
        end

        // Overflow: 19 writes into a stalled FIFO.
        do_reset();
        bus.lcd_busy_i = 1'b1;
        for (int i = 0; i < 19; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 16'h0100 + 16'(i);
            step();
            chk("ovf_level", i, 32'(bus.level_o), (i + 1 > 16) ? 32'd16 : 32'(i + 1));
            chk("ovf_full", i, 32'(bus.full_o), (i + 1 >= 16) ? 32'd1 : 32'd0);
            chk("ovf_afull", i, 32'(bus.afull_o), (i + 1 >= 12) ? 32'd1 : 32'd0);
            chk("ovf_cnt", i, 32'(bus.ovf_cnt_o), (i + 1 > 16) ? 32'(i + 1 - 16) : 32'd0);
            chk("ovf_pclk", i, 32'(bus.pix_clk_o), 32'd0);
        end
        // Write while full in the same cycle as a pop: still dropped.
        bus.in_data_i  = 16'hDEAD;
        bus.lcd_busy_i = 1'b0;
        step();
        bus.in_valid_i = 1'b0;
        chk("rw_full_level", 0, 32'(bus.level_o), 32'd15);
        chk("rw_full_ovf", 0, 32'(bus.ovf_cnt_o), 32'd4);
        got  = 0;
        last = -100;
        for (int c = 0; c < 150 && got < 16; c++) begin
            if (c > 0) step();
            if (bus.pix_clk_o) begin
                chk("drain_data", got, 32'(bus.pix_data_o), 32'h0100 + 32'(got));
                if (got > 0) chk("drain_gap", got, 32'(c - last >= 4), 32'd1);
                last = c;
                got++;
            end
        end
        chk("drain_count", 0, 32'(got), 32'd16);
        n_pc = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.pix_clk_o) n_pc++;
        end
        chk("drain_extra", 0, 32'(n_pc), 32'd0);
        chk("drain_level", 0, 32'(bus.level_o), 32'd0);

        // Sync flush with a simultaneous pixel.
        do_reset();
        bus.lcd_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 16'h0A00 + 16'(i);
            step();
        end
        chk("sync_pre_level", 0, 32'(bus.level_o), 32'd5);
        bus.in_sync_i = 1'b1;
        bus.in_data_i = 16'h1234;
        step();
        bus.in_sync_i  = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("sync_level", 0, 32'(bus.level_o), 32'd1);
        bus.lcd_busy_i = 1'b0;
        n_rc = 0;
        n_pc = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.reset_cursor_o) n_rc++;
            if (bus.pix_clk_o) n_pc++;
        end
        chk("sync_rc_count", 0, 32'(n_rc), 32'd1);
        chk("sync_pclk_count", 0, 32'(n_pc), 32'd0);
        chk("sync_pdata", 0, 32'(bus.pix_data_o), 32'd0);
        chk("sync_post_level", 0, 32'(bus.level_o), 32'd0);

        // Saturation, then asynchronous reset while a strobe is high.
        do_reset();
        bus.lcd_busy_i = 1'b1;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 316; i++) begin
            bus.in_data_i = 16'(i);
            step();
        end
        bus.in_valid_i = 1'b0;
        chk("sat_ovf", 0, 32'(bus.ovf_cnt_o), 32'hFF);
        chk("sat_full", 0, 32'(bus.full_o), 32'd1);
        bus.lcd_busy_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (bus.pix_clk_o) seen = 1'b1;
        end
        chk("arst_strobe_seen", 0, 32'(seen), 32'd1);
        if (seen) begin
            resetn = 1'b0;
            #2;
            chk("arst_pclk", 0, 32'(bus.pix_clk_o), 32'd0);
            chk("arst_rc", 0, 32'(bus.reset_cursor_o), 32'd0);
            chk("arst_pdata", 0, 32'(bus.pix_data_o), 32'd0);
            chk("arst_level", 0, 32'(bus.level_o), 32'd0);
            chk("arst_full", 0, 32'(bus.full_o), 32'd0);
            chk("arst_afull", 0, 32'(bus.afull_o), 32'd0);
            chk("arst_ovf", 0, 32'(bus.ovf_cnt_o), 32'd0);
            step();
            resetn = 1'b1;
        end
        n_pc = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.pix_clk_o) n_pc++;
        end
        chk("arst_quiet", 0, 32'(n_pc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
